// File: rtl/infer_sequencer.sv
// infer_sequencer: top-level inference sequencer between the drawing front-end,
// the accelerator core and the 7-segment display. It clears the drawing module,
// waits for a confirm press, snapshots the image and pulses the accelerator
// reset. It then waits for acc_done (or a timeout) and latches the result.
// Optional feature macro: CONFIRM_DEBOUNCE_EN adds a DEBOUNCE_CYC-cycle
// stability filter on the synchronised confirm level. The DEBOUNCE_CYC
// parameter only exists when that macro is defined.
module infer_sequencer #(
    parameter int IMG_W        = 1024,
    parameter int RESULT_W     = 4,
    parameter int RST_DELAY    = 1000,
    parameter int ACC_RST_CYC  = 2,
    parameter int TIMEOUT      = 65535
`ifdef CONFIRM_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYC = 16
`endif
) (
    input  logic                clk,
    input  logic                iRst,
    input  logic                confirm,
    input  logic                clear,
    input  logic [IMG_W-1:0]    user_image,
    input  logic                acc_done,
    input  logic [RESULT_W-1:0] acc_result,
    output logic                draw_rst_n,
    output logic                acc_ena,
    output logic                acc_rst_n,
    output logic [IMG_W-1:0]    image_out,
    output logic [RESULT_W-1:0] result,
    output logic                disp_ena,
    output logic                done,
    output logic                timeout_err
);

    // One shared phase counter serves both the drawing-reset and accelerator-reset phases.
    localparam int CNT_MAX = (RST_DELAY > ACC_RST_CYC) ? RST_DELAY : ACC_RST_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_RST_CYC - 1);
    localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_DRAW_RST = 3'd1,
        S_DRAW     = 3'd2,
        S_ACC_RST  = 3'd3,
        S_RUN      = 3'd4,
        S_SHOW     = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;

    logic conf_s1, conf_s2, conf_d;
    logic clr_s1, clr_s2;
    logic conf_lvl;
    logic confirm_edge;
    logic launch;

    // Two-flop synchronisers; preset high so a button held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (iRst) begin
            conf_s1 <= 1'b1;
            conf_s2 <= 1'b1;
            clr_s1  <= 1'b1;
            clr_s2  <= 1'b1;
        end else begin
            conf_s1 <= confirm;
            conf_s2 <= conf_s1;
            clr_s1  <= clear;
            clr_s2  <= clr_s1;
        end
    end

`ifdef CONFIRM_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            conf_f;
    logic [DB_W-1:0] db_cnt;

    // Filtered level follows the synced input only after DEBOUNCE_CYC stable cycles.
    always_ff @(posedge clk) begin
        if (iRst) begin
            conf_f <= 1'b1;
            db_cnt <= '0;
        end else if (conf_s2 == conf_f) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            conf_f <= conf_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign conf_lvl = conf_f;
`else
    assign conf_lvl = conf_s2;
`endif

    // Delayed copy of the confirm level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (iRst) conf_d <= 1'b1;
        else      conf_d <= conf_lvl;
    end

    assign confirm_edge = conf_lvl & ~conf_d;
    // Clear outranks confirm in S_SHOW.
    assign launch = confirm_edge &&
                    ((state == S_DRAW) || ((state == S_SHOW) && !clr_s2));

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (iRst) begin
            state       <= S_INIT;
            draw_rst_n  <= 1'b1;
            acc_ena     <= 1'b0;
            acc_rst_n   <= 1'b1;
            image_out   <= '0;
            result      <= '0;
            disp_ena    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            tmo         <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    draw_rst_n <= 1'b0;
                    cnt        <= '0;
                    state      <= S_DRAW_RST;
                end
                S_DRAW_RST: begin
                    if (cnt == RST_LAST) begin
                        draw_rst_n <= 1'b1;
                        cnt        <= '0;
                        state      <= S_DRAW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAW, S_SHOW: begin
                    if ((state == S_SHOW) && clr_s2) begin
                        done     <= 1'b0;
                        disp_ena <= 1'b0;
                        state    <= S_INIT;
                    end else if (launch) begin
                        image_out   <= user_image;
                        acc_ena     <= 1'b1;
                        acc_rst_n   <= 1'b0;
                        done        <= 1'b0;
                        disp_ena    <= 1'b0;
                        timeout_err <= 1'b0;
                        cnt         <= '0;
                        state       <= S_ACC_RST;
                    end
                end
                S_ACC_RST: begin
                    // acc_done is deliberately not looked at while the core is held in reset.
                    if (cnt == ACC_LAST) begin
                        acc_rst_n <= 1'b1;
                        tmo       <= '0;
                        cnt       <= '0;
                        state     <= S_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (acc_done) begin
                        result   <= acc_result;
                        disp_ena <= 1'b1;
                        done     <= 1'b1;
                        acc_ena  <= 1'b0;
                        state    <= S_SHOW;
                    end else begin
                        tmo <= tmo + 1'b1;
                        if ((TIMEOUT != 0) && (tmo == TMO_LAST)) begin
                            timeout_err <= 1'b1;
                            acc_ena     <= 1'b0;
                            disp_ena    <= 1'b0;
                            state       <= S_SHOW;
                        end
                    end
                end
                default: begin
                    acc_ena <= 1'b0;
                    state   <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_infer_sequencer.sv
// Bench for infer_sequencer: a vector table of launches with a result scoreboard,
// plus hand-written reset, clear, reset-while-held and debounce sequences.
module tb_infer_sequencer;

    localparam int IW  = 64;
    localparam int RW  = 4;
    localparam int RD  = 8;
    localparam int AR  = 2;
    localparam int TO  = 50;
`ifdef CONFIRM_DEBOUNCE_EN
    localparam int DB  = 16;
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif
    localparam int GAP = 24;

    typedef struct {
        logic [IW-1:0] img;
        int            delay;
        bit            give_done;
        logic [RW-1:0] res;
        logic [RW-1:0] exp_res;
        bit            exp_done;
        bit            exp_tmo;
    } vec_t;

    typedef struct {
        logic [IW-1:0] img;
        logic [RW-1:0] res;
        bit            done;
        bit            tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          iRst, confirm, clear, acc_done;
    logic [IW-1:0] user_image;
    logic [RW-1:0] acc_result;
    logic          draw_rst_n, acc_ena, acc_rst_n, disp_ena, done, timeout_err;
    logic [IW-1:0] image_out;
    logic [RW-1:0] result;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_launch = 0;
    logic prev_arst = 1'b1;
    exp_t sb[$];
    vec_t vt[6];
    logic [IW-1:0] last_img;

    always #5 clk = ~clk;

    infer_sequencer #(
        .IMG_W(IW), .RESULT_W(RW), .RST_DELAY(RD), .ACC_RST_CYC(AR), .TIMEOUT(TO)
`ifdef CONFIRM_DEBOUNCE_EN
        , .DEBOUNCE_CYC(DB)
`endif
    ) dut (
        .clk(clk), .iRst(iRst), .confirm(confirm), .clear(clear),
        .user_image(user_image), .acc_done(acc_done), .acc_result(acc_result),
        .draw_rst_n(draw_rst_n), .acc_ena(acc_ena), .acc_rst_n(acc_rst_n),
        .image_out(image_out), .result(result), .disp_ena(disp_ena),
        .done(done), .timeout_err(timeout_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Advance one clock, sample just after the edge, count acc_rst_n falls (launches).
    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_arst === 1'b1 && acc_rst_n === 1'b0) n_launch++;
        prev_arst = acc_rst_n;
    endtask

    task automatic draw_low_count(input string nm);
        int c;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!draw_rst_n) c++;
            else if (c > 0) break;
        end
        chk(nm, c, RD);
    endtask

    // Press confirm and check the launch edge, snapshot and acc_rst_n pulse width.
    task automatic launch(input logic [IW-1:0] img, input bit glitch);
        int lowc;
        repeat (GAP) tick();
        @(negedge clk);
        user_image = img;
        confirm    = 1'b1;
        repeat (LAT - 1) tick();
        chk("acc_rst_n before launch edge", acc_rst_n, 1);
        tick();
        chk("acc_rst_n at launch edge", acc_rst_n, 0);
        chk("image_out snapshot", image_out, img);
        chk("acc_ena at launch", acc_ena, 1);
        chk("done cleared at launch", done, 0);
        chk("timeout_err cleared at launch", timeout_err, 0);
        confirm    = 1'b0;
        user_image = {$urandom, $urandom};
        if (glitch) begin
            acc_done   = 1'b1;
            acc_result = 4'hF;
        end
        lowc = 1;
        while (lowc < 10) begin
            tick();
            if (acc_rst_n) break;
            lowc++;
        end
        acc_done = 1'b0;
        chk("acc_rst_n low cycles", lowc, AR);
        if (glitch) chk("acc_done ignored in acc reset", done, 0);
    endtask

    // Pulse acc_done so it is sampled on the delay-th edge after entering S_RUN.
    task automatic run_done(input int delay, input logic [RW-1:0] res);
        repeat (delay - 1) tick();
        acc_done   = 1'b1;
        acc_result = res;
        tick();
        acc_done   = 1'b0;
    endtask

    task automatic wait_result();
        exp_t e;
        int   k;
        k = 0;
        while (!(done || timeout_err) && k < 200) begin
            tick();
            k++;
        end
        chk("result event seen", done | timeout_err, 1);
        chk("scoreboard depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb image_out", image_out, e.img);
            chk("sb result", result, e.res);
            chk("sb done", done, e.done);
            chk("sb disp_ena", disp_ena, e.done);
            chk("sb timeout_err", timeout_err, e.tmo);
            chk("sb acc_ena off", acc_ena, 0);
        end
    endtask

    initial begin
        int   k;
        int   nl;
        exp_t e;

        vt[0] = '{64'h0000_0000_0000_00A5, 20, 1'b1, 4'd7,  4'd7,  1'b1, 1'b0};
        vt[1] = '{64'h0123_4567_89AB_CDEF, 1,  1'b1, 4'd3,  4'd3,  1'b1, 1'b0};
        vt[2] = '{64'hFFFF_0000_FFFF_0000, 0,  1'b0, 4'd0,  4'd3,  1'b0, 1'b1};
        vt[3] = '{64'h5A5A_5A5A_5A5A_5A5A, 5,  1'b1, 4'd12, 4'd12, 1'b1, 1'b0};
        vt[4] = '{64'h8000_0000_0000_0001, TO, 1'b1, 4'd0,  4'd0,  1'b1, 1'b0};
        vt[5] = '{64'hC3C3_0F0F_F0F0_3C3C, TO - 1, 1'b1, 4'd15, 4'd15, 1'b1, 1'b0};

        iRst = 1'b1; confirm = 1'b0; clear = 1'b0; acc_done = 1'b0;
        acc_result = '0; user_image = '0;

        // reset values and drawing-module reset pulse
        tick();
        chk("reset draw_rst_n", draw_rst_n, 1);
        chk("reset acc_ena", acc_ena, 0);
        chk("reset acc_rst_n", acc_rst_n, 1);
        chk("reset image_out", image_out, 0);
        chk("reset result", result, 0);
        chk("reset disp_ena", disp_ena, 0);
        chk("reset done", done, 0);
        chk("reset timeout_err", timeout_err, 0);
        @(negedge clk);
        iRst = 1'b0;
        draw_low_count("draw_rst_n low after reset");
        chk("draw idle acc_ena", acc_ena, 0);
        chk("draw idle done", done, 0);

        // table of launches, scored on done/timeout_err rising
        for (int i = 0; i < 6; i++) begin
            launch(vt[i].img, 1'b0);
            e = '{vt[i].img, vt[i].exp_res, vt[i].exp_done, vt[i].exp_tmo};
            sb.push_back(e);
            if (vt[i].give_done) begin
                run_done(vt[i].delay, vt[i].res);
            end else begin
                k = 0;
                while (!timeout_err && k < 200) begin
                    tick();
                    k++;
                end
                chk("timeout run cycles", k, TO);
            end
            wait_result();
            last_img = vt[i].img;
        end

        // clear and confirm together in S_SHOW: clear wins, drawing is re-cleared
        nl = n_launch;
        @(negedge clk);
        clear = 1'b1; confirm = 1'b1;
        repeat (3) tick();
        chk("clear drops done", done, 0);
        chk("clear drops disp_ena", disp_ena, 0);
        confirm = 1'b0; clear = 1'b0;
        draw_low_count("draw_rst_n low after clear");
        chk("no launch on clear+confirm", n_launch, nl);
        chk("image_out kept over clear", image_out, last_img);

        // reset mid-run with confirm held through it
        launch(64'h1111_2222_3333_4444, 1'b0);
        repeat (3) tick();
        @(negedge clk);
        iRst = 1'b1; confirm = 1'b1;
        tick();
        chk("midrun reset acc_ena", acc_ena, 0);
        chk("midrun reset image_out", image_out, 0);
        chk("midrun reset acc_rst_n", acc_rst_n, 1);
        @(negedge clk);
        iRst = 1'b0;
        nl = n_launch;
        repeat (30) tick();
        chk("held confirm gives no launch", n_launch, nl);
        chk("held confirm acc_ena", acc_ena, 0);
        confirm = 1'b0;
        launch(64'h0F0F_1234_ABCD_0099, 1'b1);
        e = '{64'h0F0F_1234_ABCD_0099, 4'd9, 1'b1, 1'b0};
        sb.push_back(e);
        run_done(5, 4'd9);
        wait_result();

`ifdef CONFIRM_DEBOUNCE_EN
        // short confirm glitch is filtered, a long press launches once
        nl = n_launch;
        @(negedge clk);
        confirm = 1'b1;
        repeat (10) tick();
        confirm = 1'b0;
        repeat (40) tick();
        chk("10-cycle pulse filtered", n_launch, nl);
        user_image = 64'hDB0D_DB0D_DB0D_DB0D;
        confirm = 1'b1;
        repeat (20) tick();
        confirm = 1'b0;
        k = 0;
        while (!acc_rst_n && k < 20) begin
            tick();
            k++;
        end
        chk("20-cycle pulse launches once", n_launch, nl + 1);
        e = '{64'hDB0D_DB0D_DB0D_DB0D, 4'd6, 1'b1, 1'b0};
        sb.push_back(e);
        run_done(3, 4'd6);
        wait_result();
        repeat (40) tick();
        chk("no extra launch after release", n_launch, nl + 1);
`endif

        chk("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
